// File: rtl/adder_error_evaluator_pkg.sv
// adder_error_evaluator_pkg: sweep FSM states and metric width helpers
package adder_error_evaluator_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int sum_w(input int w);
        return w + 1;
    endfunction
    function automatic int cnt_w(input int w);
        return 2 * w + 1;
    endfunction
    function automatic int acc_w(input int w);
        return 3 * w + 1;
    endfunction
endpackage

// File: rtl/adder_error_accumulator.sv
// adder_error_accumulator: per-vector error magnitude and running error metrics
module adder_error_accumulator
    import adder_error_evaluator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       enable,
    input  logic [WIDTH-1:0]           op_a,
    input  logic [WIDTH-1:0]           op_b,
    input  logic [sum_w(WIDTH)-1:0]    dut_sum,
    output logic [cnt_w(WIDTH)-1:0]    err_count,
    output logic [acc_w(WIDTH)-1:0]    sum_abs_err,
    output logic [sum_w(WIDTH)-1:0]    max_abs_err,
    output logic [WIDTH-1:0]           wc_a,
    output logic [WIDTH-1:0]           wc_b
);
    localparam int SW = sum_w(WIDTH);
    localparam int CW = cnt_w(WIDTH);
    localparam int AW = acc_w(WIDTH);
    logic [SW-1:0] exact, err;
    logic signed [SW:0] diff;
    // one extra bit keeps the difference signed; its magnitude always fits SW bits
    always_comb begin
        exact = SW'(op_a) + SW'(op_b);
        diff = $signed({1'b0, dut_sum}) - $signed({1'b0, exact});
        err = diff[SW] ? SW'(-diff) : SW'(diff);
    end
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_count <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
            wc_a <= '0;
            wc_b <= '0;
        end else if (enable) begin
            err_count <= err_count + CW'(err != '0);
            sum_abs_err <= sum_abs_err + AW'(err);
            if (err > max_abs_err) begin
                max_abs_err <= err;
                wc_a <= op_a;
                wc_b <= op_b;
            end
        end
    end
endmodule

// File: rtl/adder_error_evaluator.sv
// adder_error_evaluator: exhaustive operand sweep of an external adder with error metrics
module adder_error_evaluator
    import adder_error_evaluator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [WIDTH-1:0]           op_a,
    output logic [WIDTH-1:0]           op_b,
    input  logic [sum_w(WIDTH)-1:0]    dut_sum,
    output logic                       busy,
    output logic                       done,
    output logic [cnt_w(WIDTH)-1:0]    err_count,
    output logic [acc_w(WIDTH)-1:0]    sum_abs_err,
    output logic [sum_w(WIDTH)-1:0]    max_abs_err,
    output logic [WIDTH-1:0]           wc_a,
    output logic [WIDTH-1:0]           wc_b
);
    localparam int OW = 2 * WIDTH;
    state_t state, next;
    logic last, launch;
    always_comb begin
        last = &{op_a, op_b};
        launch = start && state != RUN;
        next = state == RUN ? (last ? DONE : RUN) : (start ? RUN : state);
    end
    // op_b is the low half, so one counter gives op_b-fastest order
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            {op_a, op_b} <= '0;
        end else begin
            state <= next;
            if (launch)
                {op_a, op_b} <= '0;
            else if (state == RUN && !last)
                {op_a, op_b} <= {op_a, op_b} + OW'(1);
        end
    end
    assign busy = state == RUN;
    assign done = state == DONE;
    adder_error_accumulator #(.WIDTH(WIDTH)) u_acc (
        .clk(clk),
        .rst(rst),
        .clear(launch),
        .enable(busy),
        .op_a(op_a),
        .op_b(op_b),
        .dut_sum(dut_sum),
        .err_count(err_count),
        .sum_abs_err(sum_abs_err),
        .max_abs_err(max_abs_err),
        .wc_a(wc_a),
        .wc_b(wc_b)
    );
endmodule

// File: tb/tb_adder_error_evaluator.sv
// tb_adder_error_evaluator: directed sweeps at WIDTH=6 and WIDTH=2 with a result scoreboard
module tb_adder_error_evaluator;
    typedef struct {
        int cnt;
        int sae;
        int mae;
        int wa;
        int wb;
    } res_t;

    logic clk = 0, rst = 1, start6 = 0, start2 = 0;
    int mode = 0;
    int checks = 0, errors = 0;
    res_t exp_q[$];

    logic [5:0] op_a6, op_b6, wc_a6, wc_b6;
    logic [6:0] sum6, mae6;
    logic [12:0] cnt6;
    logic [18:0] sae6;
    logic busy6, done6;

    logic [1:0] op_a2, op_b2, wc_a2, wc_b2;
    logic [2:0] sum2, mae2;
    logic [4:0] cnt2;
    logic [6:0] sae2;
    logic busy2, done2;
    logic c1;

    always #5 clk = ~clk;

    // adder variants under test at WIDTH=6
    always_comb begin
        sum6 = 7'(op_a6) + 7'(op_b6);
        if (mode == 1) sum6[0] = 1'b0;
        if (mode == 2) sum6 = '0;
        if (mode == 3 && op_a6 == 6'd5 && op_b6 == 6'd7) sum6 = sum6 + 7'd1;
    end

    // two approximate LSB cells: carry-out ignores carry-in
    always_comb begin
        c1 = op_a2[0] & op_b2[0];
        sum2 = {op_a2[1] & op_b2[1], op_a2[1] ^ op_b2[1] ^ c1, op_a2[0] ^ op_b2[0]};
    end

    adder_error_evaluator #(.WIDTH(6)) u6 (
        .clk(clk), .rst(rst), .start(start6), .op_a(op_a6), .op_b(op_b6),
        .dut_sum(sum6), .busy(busy6), .done(done6), .err_count(cnt6),
        .sum_abs_err(sae6), .max_abs_err(mae6), .wc_a(wc_a6), .wc_b(wc_b6)
    );

    adder_error_evaluator #(.WIDTH(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .op_a(op_a2), .op_b(op_b2),
        .dut_sum(sum2), .busy(busy2), .done(done2), .err_count(cnt2),
        .sum_abs_err(sae2), .max_abs_err(mae2), .wc_a(wc_a2), .wc_b(wc_b2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic res_t model2();
        res_t r = '{0, 0, 0, 0, 0};
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++) begin
                int ex, ap, e;
                int a0 = a & 1, a1 = a >> 1, b0 = b & 1, b1 = b >> 1;
                ex = a + b;
                ap = (a0 ^ b0) + 2 * (a1 ^ b1 ^ (a0 & b0)) + 4 * (a1 & b1);
                e = ap > ex ? ap - ex : ex - ap;
                if (e != 0) r.cnt++;
                r.sae += e;
                if (e > r.mae) begin
                    r.mae = e;
                    r.wa = a;
                    r.wb = b;
                end
            end
        return r;
    endfunction

    task automatic cmp6(input string tag);
        res_t e = exp_q.pop_front();
        chk({tag, "_cnt"}, int'(cnt6), e.cnt);
        chk({tag, "_sae"}, int'(sae6), e.sae);
        chk({tag, "_mae"}, int'(mae6), e.mae);
        chk({tag, "_wca"}, int'(wc_a6), e.wa);
        chk({tag, "_wcb"}, int'(wc_b6), e.wb);
    endtask

    task automatic cmp2(input string tag);
        res_t e = exp_q.pop_front();
        chk({tag, "_cnt"}, int'(cnt2), e.cnt);
        chk({tag, "_sae"}, int'(sae2), e.sae);
        chk({tag, "_mae"}, int'(mae2), e.mae);
        chk({tag, "_wca"}, int'(wc_a2), e.wa);
        chk({tag, "_wcb"}, int'(wc_b2), e.wb);
    endtask

    task automatic sweep6(input int m, input res_t e, input string tag);
        int n = 0;
        mode = m;
        exp_q.push_back(e);
        @(negedge clk) start6 = 1;
        @(negedge clk) start6 = 0;
        while (busy6 && n < 5000) begin
            if (n == 3) chk({tag, "_ord3"}, int'({op_a6, op_b6}), 3);
            if (n == 65) chk({tag, "_ord65"}, int'({op_a6, op_b6}), 65);
            @(negedge clk);
            n++;
        end
        chk({tag, "_busy_cycles"}, n, 4096);
        chk({tag, "_done"}, int'(done6), 1);
        chk({tag, "_op_hold"}, int'({op_a6, op_b6}), 4095);
        cmp6(tag);
    endtask

    task automatic sweep2(input string tag, input bit poke);
        int n = 0;
        exp_q.push_back(model2());
        @(negedge clk) start2 = 1;
        @(negedge clk) start2 = 0;
        while (busy2 && n < 100) begin
            start2 = poke && n == 4;
            @(negedge clk);
            n++;
        end
        start2 = 0;
        chk({tag, "_busy_cycles"}, n, 16);
        chk({tag, "_done"}, int'(done2), 1);
        cmp2(tag);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy6), 0);
        chk("rst_done", int'(done6), 0);
        chk("rst_outs", int'({cnt6, sae6, mae6, wc_a6, wc_b6, op_a6, op_b6}), 0);
        rst = 0;
        @(negedge clk);
        chk("idle_busy", int'(busy6), 0);

        sweep6(0, '{0, 0, 0, 0, 0}, "exact");
        repeat (3) @(negedge clk);
        chk("done_hold", int'(done6), 1);
        sweep6(1, '{2048, 2048, 1, 0, 1}, "bit0");
        sweep6(2, '{4095, 258048, 126, 63, 63}, "zero");
        sweep6(3, '{1, 1, 1, 5, 7}, "flip57");

        mode = 2;
        @(negedge clk) start6 = 1;
        @(negedge clk) start6 = 0;
        repeat (100) @(negedge clk);
        chk("pre_rst_busy", int'(busy6), 1);
        rst = 1;
        @(negedge clk) rst = 0;
        chk("mid_rst_busy", int'(busy6), 0);
        chk("mid_rst_done", int'(done6), 0);
        chk("mid_rst_outs", int'({cnt6, sae6, mae6, wc_a6, wc_b6, op_a6, op_b6}), 0);
        @(negedge clk);
        chk("mid_rst_idle", int'(busy6), 0);
        sweep6(0, '{0, 0, 0, 0, 0}, "after_rst");

        sweep2("w2", 1'b1);
        sweep2("w2_rerun", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
